// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM: fetch/decode/execute/memory/writeback over a shared ALU and one memory port.
// Optional macro MC_BNE_EN adds bne (branch funct3=001) to the BEQ state.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 15,
  parameter int INSTRET_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero_flag,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 ir_write,
  output logic                 adr_src,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 reg_write,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           result_src,
  output logic [3:0]           alu_operation,
  output logic                 fault,
  output logic [INSTRET_W-1:0] instret
);

  // state    | meaning
  // FETCH    | read instruction at PC, PC <- PC+4 on mem_ready
  // DECODE   | branch target into ALU-out, dispatch on opcode
  // MEMADR   | rs1 + imm into ALU-out
  // MEMREAD  | load access, wait for mem_ready
  // MEMWB    | load data to register file, retire
  // MEMWRITE | store access, retire on mem_ready
  // EXECR    | rs1 op rs2
  // EXECI    | rs1 op imm
  // ALUWB    | ALU-out to register file, retire
  // BEQ      | compare rs1/rs2, conditional PC load, retire
  // JAL      | PC <- target, ALU computes link address
  // FAULT    | illegal instruction or memory timeout, sticky until rst
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_FAULT
  } state_t;

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       wait_cnt;
  logic                   mem_state;
  logic                   timeout;
  logic                   retire;
  logic [3:0]             alu_op_dec;
  logic                   alu_legal;
  logic                   br_legal;
  logic                   br_take;
  logic                   pc_write_s, ir_write_s, mem_read_s, mem_write_s, reg_write_s;

  assign mem_state = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
  // The current not-ready cycle is the MEM_TIMEOUT-th consecutive one.
  assign timeout   = mem_state && !mem_ready && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    alu_op_dec = OP_ADD;
    alu_legal  = 1'b1;
    case (funct3)
      3'b000:  if (state == S_EXECR && funct7b5) alu_op_dec = OP_SUB;
      3'b111:  alu_op_dec = OP_AND;
      3'b110:  alu_op_dec = OP_OR;
      3'b010:  alu_op_dec = OP_SLT;
      default: alu_legal = 1'b0;
    endcase
  end

  always_comb begin
    br_legal = 1'b0;
    br_take  = 1'b0;
    case (funct3)
      3'b000: begin
        br_legal = 1'b1;
        br_take  = zero_flag;
      end
`ifdef MC_BNE_EN
      3'b001: begin
        br_legal = 1'b1;
        br_take  = ~zero_flag;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_nxt     = state;
    pc_write_s    = 1'b0;
    ir_write_s    = 1'b0;
    adr_src       = 1'b0;
    mem_read_s    = 1'b0;
    mem_write_s   = 1'b0;
    reg_write_s   = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    result_src    = 2'b00;
    alu_operation = OP_ADD;
    retire        = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read_s = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready) begin
          ir_write_s = 1'b1;
          pc_write_s = 1'b1;
          state_nxt  = S_DECODE;
        end else if (timeout) begin
          state_nxt = S_FAULT;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OPC_LOAD, OPC_STORE: state_nxt = S_MEMADR;
          OPC_RTYPE:           state_nxt = S_EXECR;
          OPC_ITYPE:           state_nxt = S_EXECI;
          OPC_BRANCH:          state_nxt = S_BEQ;
          OPC_JAL:             state_nxt = S_JAL;
          default:             state_nxt = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_nxt = (opcode == OPC_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_read_s = 1'b1;
        adr_src    = 1'b1;
        if (mem_ready)    state_nxt = S_MEMWB;
        else if (timeout) state_nxt = S_FAULT;
      end
      S_MEMWB: begin
        result_src  = 2'b01;
        reg_write_s = 1'b1;
        retire      = 1'b1;
        state_nxt   = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_write_s = 1'b1;
        adr_src     = 1'b1;
        if (mem_ready) begin
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end else if (timeout) begin
          state_nxt = S_FAULT;
        end
      end
      S_EXECR, S_EXECI: begin
        alu_src_a     = 2'b10;
        alu_src_b     = (state == S_EXECI) ? 2'b01 : 2'b00;
        alu_operation = alu_op_dec;
        state_nxt     = alu_legal ? S_ALUWB : S_FAULT;
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
        retire      = 1'b1;
        state_nxt   = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a     = 2'b10;
        alu_operation = OP_SUB;
        if (br_legal) begin
          pc_write_s = br_take;
          retire     = 1'b1;
          state_nxt  = S_FETCH;
        end else begin
          state_nxt = S_FAULT;
        end
      end
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write_s = 1'b1;
        state_nxt  = S_ALUWB;
      end
      S_FAULT: state_nxt = S_FAULT;
      default: state_nxt = S_FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      instret  <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || !mem_state) wait_cnt <= '0;
      else                                  wait_cnt <= wait_cnt + 1'b1;
      if (retire) instret <= instret + 1'b1;
    end
  end

  // Strobes are held off for the whole reset cycle, whatever the old state.
  assign pc_write  = pc_write_s  & ~rst;
  assign ir_write  = ir_write_s  & ~rst;
  assign mem_read  = mem_read_s  & ~rst;
  assign mem_write = mem_write_s & ~rst;
  assign reg_write = reg_write_s & ~rst;
  assign fault     = (state == S_FAULT);

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: per-instruction cycle schedules built from the control rules.
module tb_multicycle_controller;
  localparam int T  = 4;
  localparam int IW = 4;

  localparam logic [3:0] ADD = 4'b0010;
  localparam logic [3:0] SUB = 4'b0110;
  localparam logic [16:0] STB_MASK = 17'b11_0111_0000_0000_000;

  localparam logic [6:0] OPC_LW = 7'b0000011;
  localparam logic [6:0] OPC_SW = 7'b0100011;
  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_I  = 7'b0010011;
  localparam logic [6:0] OPC_BR = 7'b1100011;
  localparam logic [6:0] OPC_J  = 7'b1101111;

  typedef enum int {K_LW, K_SW, K_R, K_I, K_BR, K_JAL, K_ILL} kind_t;
  typedef struct {
    logic        rdy;
    logic        zf;
    logic [16:0] ctrl;
  } cyc_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic funct7b5 = 1'b0, zero_flag = 1'b0, mem_ready = 1'b0;
  logic pc_write, ir_write, adr_src, mem_read, mem_write, reg_write, fault;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [3:0] alu_operation;
  logic [IW-1:0] instret;
  logic [16:0] ctrl;

  cyc_t sched[$];
  int checks = 0;
  int errors = 0;
  int instr_no = 0;
  logic [IW-1:0] exp_instret = '0;
  bit [2:0] alu_f3 [4] = '{3'd0, 3'd7, 3'd6, 3'd2};
  logic [6:0] ill_ops [6] = '{7'h7f, 7'h00, 7'h37, 7'h17, 7'h67, 7'h73};

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_TIMEOUT(T), .INSTRET_W(IW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .zero_flag(zero_flag), .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .adr_src(adr_src), .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .alu_operation(alu_operation), .fault(fault), .instret(instret)
  );

  assign ctrl = {pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
                 alu_src_a, alu_src_b, result_src, alu_operation, fault};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] mk(bit pcw, bit irw, bit adr, bit mr, bit mw, bit rw,
                                     bit [1:0] a, bit [1:0] b, bit [1:0] rs, bit [3:0] op, bit f);
    return {pcw, irw, adr, mr, mw, rw, a, b, rs, op, f};
  endfunction

  function automatic void push(bit r, bit z, logic [16:0] c);
    cyc_t e;
    e.rdy  = r;
    e.zf   = z;
    e.ctrl = c;
    sched.push_back(e);
  endfunction

  // w not-ready cycles then a ready one; w >= T means the access times out.
  function automatic bit add_wait(logic [16:0] cw, logic [16:0] cd, int w, bit z);
    if (w >= T) begin
      for (int i = 0; i < T; i++) push(1'b0, z, cw);
      return 1'b0;
    end
    for (int i = 0; i < w; i++) push(1'b0, z, cw);
    push(1'b1, z, cd);
    return 1'b1;
  endfunction

  function automatic int alu_ref(bit rtype, bit [2:0] f3, bit f7);
    case (f3)
      3'b000:  return (rtype && f7) ? int'(SUB) : int'(ADD);
      3'b111:  return 0;
      3'b110:  return 1;
      3'b010:  return 7;
      default: return -1;
    endcase
  endfunction

  function automatic int br_ref(bit [2:0] f3, bit zf);
    if (f3 == 3'b000) return int'(zf);
`ifdef MC_BNE_EN
    if (f3 == 3'b001) return int'(!zf);
`endif
    return -1;
  endfunction

  task automatic do_reset(int n);
    rst = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("rst%0d strobes", i), 32'(ctrl & STB_MASK), 32'd0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    exp_instret = '0;
  endtask

  task automatic run_instr(kind_t k, logic [6:0] op7, bit [2:0] f3, bit f7, bit zf,
                           int fw, int mw, int cut);
    bit ok, retired;
    int r, n;
    logic [16:0] mem_c;
    sched.delete();
    instr_no++;
    opcode = op7; funct3 = f3; funct7b5 = f7;
    retired = 1'b0;
    ok = add_wait(mk(0,0,0,1,0,0,2'b00,2'b10,2'b10,ADD,0),
                  mk(1,1,0,1,0,0,2'b00,2'b10,2'b10,ADD,0), fw, zf);
    if (ok) begin
      push(1'($urandom_range(1)), zf, mk(0,0,0,0,0,0,2'b01,2'b01,2'b00,ADD,0));
      case (k)
        K_LW, K_SW: begin
          push(1'($urandom_range(1)), zf, mk(0,0,0,0,0,0,2'b10,2'b01,2'b00,ADD,0));
          mem_c = (k == K_LW) ? mk(0,0,1,1,0,0,2'b00,2'b00,2'b00,ADD,0)
                              : mk(0,0,1,0,1,0,2'b00,2'b00,2'b00,ADD,0);
          ok = add_wait(mem_c, mem_c, mw, zf);
          if (ok && k == K_LW)
            push(1'($urandom_range(1)), zf, mk(0,0,0,0,0,1,2'b00,2'b00,2'b01,ADD,0));
          retired = ok;
        end
        K_R, K_I: begin
          r = alu_ref(k == K_R, f3, f7);
          push(1'($urandom_range(1)), zf, mk(0,0,0,0,0,0,2'b10, (k == K_R) ? 2'b00 : 2'b01,
                                            2'b00, (r < 0) ? ADD : 4'(r), 0));
          ok = (r >= 0);
          if (ok) push(1'($urandom_range(1)), zf, mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,ADD,0));
          retired = ok;
        end
        K_BR: begin
          r = br_ref(f3, zf);
          push(1'($urandom_range(1)), zf, mk(r == 1,0,0,0,0,0,2'b10,2'b00,2'b00,SUB,0));
          ok = (r >= 0);
          retired = ok;
        end
        K_JAL: begin
          push(1'($urandom_range(1)), zf, mk(1,0,0,0,0,0,2'b01,2'b10,2'b00,ADD,0));
          push(1'($urandom_range(1)), zf, mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,ADD,0));
          retired = 1'b1;
        end
        default: ok = 1'b0;
      endcase
    end
    if (!ok)
      for (int i = 0; i < 3; i++)
        push(1'($urandom_range(1)), 1'($urandom_range(1)), mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,ADD,1));
    n = (cut > 0 && cut < sched.size()) ? cut : sched.size();
    for (int i = 0; i < n; i++) begin
      mem_ready = sched[i].rdy;
      zero_flag = sched[i].zf;
      @(negedge clk);
      check($sformatf("i%0d k%0d c%0d ctrl", instr_no, int'(k), i), 32'(ctrl), 32'(sched[i].ctrl));
      check($sformatf("i%0d c%0d instret", instr_no, i), 32'(instret), 32'(exp_instret));
      @(posedge clk); #1;
    end
    if (n < sched.size() || !ok) do_reset(2);
    else if (retired) exp_instret = exp_instret + 1'b1;
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset(2);
    run_instr(K_R,   OPC_R,  3'b000, 1'b0, 1'b0, 0, 0, 0);
    run_instr(K_R,   OPC_R,  3'b000, 1'b1, 1'b0, 0, 0, 0);
    run_instr(K_I,   OPC_I,  3'b000, 1'b1, 1'b0, 0, 0, 0);
    run_instr(K_LW,  OPC_LW, 3'b010, 1'b0, 1'b0, 0, 3, 0);
    run_instr(K_SW,  OPC_SW, 3'b010, 1'b0, 1'b0, 1, 2, 0);
    run_instr(K_BR,  OPC_BR, 3'b000, 1'b0, 1'b1, 0, 0, 0);
    run_instr(K_BR,  OPC_BR, 3'b000, 1'b0, 1'b0, 0, 0, 0);
    run_instr(K_JAL, OPC_J,  3'b000, 1'b0, 1'b0, 0, 0, 0);
    run_instr(K_R,   OPC_R,  3'b111, 1'b0, 1'b0, 0, 0, 0);
    run_instr(K_I,   OPC_I,  3'b110, 1'b0, 1'b0, 0, 0, 0);
    run_instr(K_R,   OPC_R,  3'b010, 1'b0, 1'b0, 0, 0, 0);
    run_instr(K_R,   OPC_R,  3'b000, 1'b0, 1'b0, T-1, 0, 0);
    run_instr(K_SW,  OPC_SW, 3'b010, 1'b0, 1'b0, 0, T-1, 0);
    for (int i = 0; i < 8; i++) run_instr(K_I, OPC_I, 3'b000, 1'b0, 1'b0, 0, 1, 0);
    run_instr(K_R,   OPC_R,  3'b000, 1'b0, 1'b0, T, 0, 0);
    run_instr(K_LW,  OPC_LW, 3'b010, 1'b0, 1'b0, 0, T, 0);
    run_instr(K_ILL, 7'h7f,  3'b000, 1'b0, 1'b0, 0, 0, 0);
    run_instr(K_BR,  OPC_BR, 3'b001, 1'b0, 1'b0, 0, 0, 0);
    run_instr(K_R,   OPC_R,  3'b001, 1'b0, 1'b0, 0, 0, 0);
    run_instr(K_LW,  OPC_LW, 3'b010, 1'b0, 1'b0, 0, 3, 5);
    for (int n = 0; n < 300; n++) begin
      int sel;
      kind_t k;
      logic [6:0] op7;
      bit [2:0] f3;
      int fw, mw, cut;
      sel = int'($urandom_range(19));
      if (sel < 4)       begin k = K_LW;  op7 = OPC_LW; end
      else if (sel < 7)  begin k = K_SW;  op7 = OPC_SW; end
      else if (sel < 11) begin k = K_R;   op7 = OPC_R;  end
      else if (sel < 14) begin k = K_I;   op7 = OPC_I;  end
      else if (sel < 17) begin k = K_BR;  op7 = OPC_BR; end
      else if (sel < 19) begin k = K_JAL; op7 = OPC_J;  end
      else               begin k = K_ILL; op7 = ill_ops[$urandom_range(5)]; end
      if (k == K_BR) f3 = ($urandom_range(3) == 0) ? 3'b001 : 3'b000;
      else if ($urandom_range(9) == 0) f3 = 3'($urandom_range(7));
      else f3 = alu_f3[$urandom_range(3)];
      fw  = ($urandom_range(29) == 0) ? int'($urandom_range(T-1, T+1)) : int'($urandom_range(2));
      mw  = ($urandom_range(29) == 0) ? int'($urandom_range(T-1, T+1)) : int'($urandom_range(2));
      cut = ($urandom_range(39) == 0) ? int'($urandom_range(1, 6)) : 0;
      run_instr(k, op7, f3, 1'($urandom_range(1)), 1'($urandom_range(1)), fw, mw, cut);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle successor to the single-cycle control path: one FSM sequencing fetch/decode/execute/memory/writeback over several clocks, sharing one ALU and one unified memory port.
- Merges main decode and ALU-operation decode.
- Adds a memory ready handshake with a parametrised timeout, a sticky fault state and a retired-instruction counter.
- Drives the multi-cycle datapath's muxes and write strobes.

Parameters:
MEM_TIMEOUT, 15, max consecutive cycles a memory state waits for mem_ready before entering FAULT (>=1)
INSTRET_W, 32, width of retired-instruction counter (wraps modulo 2^INSTRET_W)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
opcode  input  7  instruction[6:0] from instruction register
funct3  input  3  instruction[14:12]
funct7b5  input  1  instruction[30]
zero_flag  input  1  ALU zero, combinational from datapath
mem_ready  input  1  memory completes access this cycle
pc_write  output  1  load PC
ir_write  output  1  load instruction register and old-PC register
adr_src  output  1  0=PC, 1=ALU-out register drives memory address
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
reg_write  output  1  register file write enable
alu_src_a  output  2  00=PC, 01=old PC, 10=rs1
alu_src_b  output  2  00=rs2, 01=immediate, 10=constant 4
result_src  output  2  00=ALU-out register, 01=memory data, 10=ALU result
alu_operation  output  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT
fault  output  1  sticky illegal-instruction / memory-timeout flag
instret  output  INSTRET_W  count of retired instructions

Behaviour:
- Moore FSM; all outputs decoded from the current state only, except:
  - alu_operation in EXECR/EXECI, which is decoded from funct3/funct7b5.
  - pc_write in FETCH and BEQ.
  - ir_write in FETCH.
- Any output not listed for a state is 0; alu_operation default is ADD.
- Reset: state=FETCH, wait counter=0, instret=0, fault=0. While rst=1, all strobes (pc_write, ir_write, mem_read, mem_write, reg_write) are forced 0.
- FETCH: mem_read=1, adr_src=0, a=00, b=10, ADD, result_src=10.
  - If mem_ready: ir_write=1, pc_write=1, then go to DECODE.
  - Else stay in FETCH.
- DECODE: a=01, b=01, ADD (branch target into ALU-out). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - any other opcode -> FAULT
- MEMADR: a=10, b=01, ADD. Go to MEMREAD if opcode=0000011, else MEMWRITE.
- MEMREAD: mem_read=1, adr_src=1. Wait for mem_ready, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1, instret++, go to FETCH.
- MEMWRITE: mem_write=1, adr_src=1. Wait for mem_ready, then instret++ and go to FETCH.
- EXECR: a=10, b=00. EXECI: a=10, b=01. Both go to ALUWB. Operation by funct3:
  - 000: ADD, or SUB when R-type and funct7b5=1
  - 111: AND
  - 110: OR
  - 010: SLT
  - any other funct3 -> FAULT instead of ALUWB
- ALUWB: result_src=00, reg_write=1, instret++, go to FETCH.
- BEQ: a=10, b=00, SUB, result_src=00.
  - pc_write=zero_flag if funct3=000; other funct3 -> FAULT (see Optional Feature).
  - instret++, go to FETCH.
- JAL: a=01, b=10, ADD, result_src=00, pc_write=1 (PC <- target, ALU computes old PC+4). Go to ALUWB, which retires the instruction.
- FAULT: fault=1, all strobes 0, absorbing until rst.
- Memory wait counter:
  - Increments each cycle FETCH/MEMREAD/MEMWRITE is held with mem_ready=0; clears on any state change.
  - When count reaches MEM_TIMEOUT with mem_ready still 0, go to FAULT next cycle.
  - mem_ready=1 on the same cycle count reaches MEM_TIMEOUT: the access completes and there is no fault.
- instret wraps from all-ones to 0 without flagging.
- rst asserted in any state, including mid-wait or in FAULT, returns to the reset condition next edge.

Optional Feature:
- Macro MC_BNE_EN.
- Defined: BEQ state also accepts funct3=001 (bne) with pc_write=~zero_flag; retires normally.
- Undefined: branch funct3=001 goes to FAULT like any other unsupported branch funct3.

Test Plan:
- rst=1 two cycles, release with mem_ready=1 -> cycle 1 FETCH with mem_read=1, ir_write=1, pc_write=1; instret=0, fault=0; no strobe while rst high.
- R-type add (opcode 0110011, funct3 000, funct7b5 0), mem_ready=1 -> FETCH, DECODE, EXECR (op 0010), ALUWB (reg_write=1): 4 cycles, instret=1. Repeat with funct7b5=1 -> op 0110.
- lw with mem_ready low 3 cycles in MEMREAD -> 8 cycles total, mem_read/adr_src=1 held throughout, reg_write in MEMWB, instret +1. sw -> mem_write=1 for exactly the waiting cycles plus the ready cycle.
- beq with zero_flag=1 -> pc_write=1 in BEQ; with zero_flag=0 -> pc_write=0; both retire. jal -> pc_write=1 in JAL, then reg_write=1 in ALUWB.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> FAULT after 4 wait cycles, fault=1 sticky, no strobes; mem_ready=1 exactly on the 4th cycle -> no fault.
- Illegal opcode 1111111 -> FAULT from DECODE. funct3=001 branch -> FAULT without MC_BNE_EN; with MC_BNE_EN and zero_flag=0 -> pc_write=1. rst in FAULT -> FETCH, fault=0.
